// File: rtl/fnd_scan_decoder.sv
// FND scan receiver: deglitches a time-multiplexed 4-digit 7-segment bus,
// decodes each digit back to a hex nibble and publishes complete frames.
module fnd_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [3:0]  i_FND_Digit,
  input  logic [7:0]  i_FND_Font,
  output logic [15:0] o_value,
  output logic [3:0]  o_dp,
  output logic [3:0]  o_blank,
  output logic        o_frame,
  output logic        o_valid,
  output logic        o_err
);

  localparam logic [7:0] StableMax = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {StIdle, StSettle, StHeld} state_e;

  state_e      state_q, state_d;
  logic [3:0]  d_q, d_p;
  logic [7:0]  f_q, f_p;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  dp_s_q, dp_s_d;
  logic [3:0]  blank_s_q, blank_s_d;
  logic [3:0]  mask_q, mask_d;
  logic        err_acc_q, err_acc_d;
  logic [15:0] value_d;
  logic [3:0]  dp_d, blank_d;
  logic        frame_d, valid_d, err_d;

  logic        changed, fire, legal, is_blank, complete;
  logic [1:0]  idx;
  logic [4:0]  dec;

  // Active-low font to {hit, nibble}; hit=0 for any non-hex pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h40: return 5'h10;
      7'h79: return 5'h11;
      7'h24: return 5'h12;
      7'h30: return 5'h13;
      7'h19: return 5'h14;
      7'h12: return 5'h15;
      7'h02: return 5'h16;
      7'h78: return 5'h17;
      7'h00: return 5'h18;
      7'h10: return 5'h19;
      7'h08: return 5'h1A;
      7'h03: return 5'h1B;
      7'h46: return 5'h1C;
      7'h21: return 5'h1D;
      7'h06: return 5'h1E;
      7'h0E: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  // Stage-0 sampling, stability counter, FSM, capture shadows and output frame.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      // Idle pattern so the cleared stage 0 never looks like a selected digit.
      d_q       <= 4'hF;
      f_q       <= 8'hFF;
      d_p       <= 4'hF;
      f_p       <= 8'hFF;
      cnt_q     <= 8'd0;
      state_q   <= StIdle;
      shadow_q  <= 16'h0000;
      dp_s_q    <= 4'h0;
      blank_s_q <= 4'h0;
      mask_q    <= 4'h0;
      err_acc_q <= 1'b0;
      o_value   <= 16'h0000;
      o_dp      <= 4'h0;
      o_blank   <= 4'h0;
      o_frame   <= 1'b0;
      o_valid   <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      d_q       <= i_FND_Digit;
      f_q       <= i_FND_Font;
      d_p       <= d_q;
      f_p       <= f_q;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      dp_s_q    <= dp_s_d;
      blank_s_q <= blank_s_d;
      mask_q    <= mask_d;
      err_acc_q <= err_acc_d;
      o_value   <= value_d;
      o_dp      <= dp_d;
      o_blank   <= blank_d;
      o_frame   <= frame_d;
      o_valid   <= valid_d;
      o_err     <= err_d;
    end
  end

  // Stability tracking and state transitions; one action per stable run.
  always_comb begin
    changed = (d_q != d_p) || (f_q != f_p);
    if (changed) begin
      cnt_d = 8'd1;
    end else if (cnt_q >= StableMax) begin
      cnt_d = StableMax;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
    fire = (d_q != 4'hF) && (cnt_d == StableMax) && (changed || (state_q != StHeld));
    if (d_q == 4'hF) begin
      state_d = StIdle;
    end else if (fire || ((state_q == StHeld) && !changed)) begin
      state_d = StHeld;
    end else begin
      state_d = StSettle;
    end
  end

  // Digit capture, error accumulation and frame publication.
  always_comb begin
    shadow_d  = shadow_q;
    dp_s_d    = dp_s_q;
    blank_s_d = blank_s_q;
    mask_d    = mask_q;
    err_acc_d = err_acc_q;
    value_d   = o_value;
    dp_d      = o_dp;
    blank_d   = o_blank;
    frame_d   = 1'b0;
    valid_d   = o_valid;
    err_d     = o_err;

    legal    = $onehot(~d_q);
    is_blank = (f_q[6:0] == 7'h7F);
    dec      = seg_decode(f_q[6:0]);
    idx      = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!d_q[i]) idx = 2'(i);
    end

    complete = (mask_q == 4'hF);
    if (complete) begin
      value_d   = shadow_q;
      dp_d      = dp_s_q;
      blank_d   = blank_s_q;
      frame_d   = 1'b1;
      valid_d   = 1'b1;
      err_d     = err_acc_q;
      mask_d    = 4'h0;
      err_acc_d = 1'b0;
    end

    // Actions on the loading edge land in the next frame.
    if (fire) begin
      if (legal && (dec[4] || is_blank)) begin
        shadow_d[idx*4 +: 4] = is_blank ? 4'h0 : dec[3:0];
        blank_s_d[idx]       = is_blank;
        dp_s_d[idx]          = ~f_q[7];
        mask_d[idx]          = 1'b1;
      end else begin
        err_acc_d = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Directed bench for fnd_scan_decoder: scans are driven digit by digit, the
// frame each scan should produce is queued, and the monitor pops on o_frame.
module tb_fnd_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  dig;
  logic [7:0]  font;
  logic [15:0] o_value;
  logic [3:0]  o_dp, o_blank;
  logic        o_frame, o_valid, o_err;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        err;
  } frame_t;

  frame_t exp_q[$];
  int     n_vec = 0;
  int     n_err = 0;
  int     frames = 0;
  int     frames_ref;

  fnd_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_FND_Digit (dig),
    .i_FND_Font  (font),
    .o_value     (o_value),
    .o_dp        (o_dp),
    .o_blank     (o_blank),
    .o_frame     (o_frame),
    .o_valid     (o_valid),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [3:0] sel(input int n);
    logic [3:0] one;
    one = 4'b0001 << n;
    return ~one;
  endfunction

  task automatic hold(input logic [3:0] d, input logic [7:0] f, input int cycles);
    dig  = d;
    font = f;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic hold_hex(input int n, input logic [3:0] v);
    hold(sel(n), {1'b1, seg7(v)}, 8);
  endtask

  // Full scan digit0..digit3, 8 cycles each; the frame it completes is queued first.
  task automatic scan4(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] blank,
                       input logic err);
    exp_q.push_back('{value: v, dp: dp, blank: blank, err: err});
    for (int n = 0; n < 4; n++) begin
      hold(sel(n), {~dp[n], blank[n] ? 7'h7F : seg7(v[n*4 +: 4])}, 8);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, 16'(exp_q.size()), 16'd0);
  endtask

  // Scoreboard side: every published frame must match the oldest queued one.
  always @(negedge clk) begin
    if (rst_n && o_frame) begin
      frame_t e;
      frames++;
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL spurious_frame: observed frame with value %h, expected none", o_value);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("frame_value", o_value, e.value);
        check("frame_dp", 16'(o_dp), 16'(e.dp));
        check("frame_blank", 16'(o_blank), 16'(e.blank));
        check("frame_err", 16'(o_err), 16'(e.err));
        check("frame_valid", 16'(o_valid), 16'd1);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    dig   = 4'hF;
    font  = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_value", o_value, 16'h0000);
    check("rst_dp", 16'(o_dp), 16'd0);
    check("rst_blank", 16'(o_blank), 16'd0);
    check("rst_frame", 16'(o_frame), 16'd0);
    check("rst_valid", 16'(o_valid), 16'd0);
    check("rst_err", 16'(o_err), 16'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Scan 1234: fonts F9, A4, B0, 99.
    scan4(16'h4321, 4'h0, 4'h0, 1'b0);
    drain("scan_1234_frame");

    // Glitch: digit0 present for only 3 edges must not capture.
    frames_ref = frames;
    hold(sel(0), {1'b1, seg7(4'h9)}, 3);
    hold_hex(1, 4'h5);
    hold_hex(2, 4'h6);
    hold_hex(3, 4'h7);
    repeat (4) @(negedge clk);
    check("glitch_no_frame", 16'(frames), 16'(frames_ref));
    exp_q.push_back('{value: 16'h7658, dp: 4'h0, blank: 4'h0, err: 1'b0});
    hold_hex(0, 4'h8);
    drain("glitch_late_frame");

    // Illegal digit select flags the next frame only.
    hold(4'b1100, {1'b1, seg7(4'h1)}, 6);
    scan4(16'h2468, 4'h0, 4'h0, 1'b1);
    drain("illegal_err_frame");
    scan4(16'hBEEF, 4'h0, 4'h0, 1'b0);
    drain("illegal_clean_frame");

    // Blank digit2 and digit1 showing 0 with dp lit.
    scan4(16'hA003, 4'b0010, 4'b0100, 1'b0);
    drain("blank_dp_frame");
    check("blank_held_value", o_value, 16'hA003);

    // Invalid font on digit0 leaves its mask bit clear.
    frames_ref = frames;
    hold(sel(0), 8'hFE, 8);
    hold_hex(1, 4'h7);
    hold_hex(2, 4'h8);
    hold_hex(3, 4'h9);
    repeat (4) @(negedge clk);
    check("badfont_no_frame", 16'(frames), 16'(frames_ref));
    exp_q.push_back('{value: 16'h9875, dp: 4'h0, blank: 4'h0, err: 1'b1});
    hold_hex(0, 4'h5);
    drain("badfont_frame");
    check("badfont_err_held", 16'(o_err), 16'd1);

    // Reset mid-frame drops the digit0/digit1 captures.
    hold_hex(0, 4'h1);
    hold_hex(1, 4'h2);
    hold(4'hF, 8'hFF, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_value", o_value, 16'h0000);
    check("midrst_dp", 16'(o_dp), 16'd0);
    check("midrst_blank", 16'(o_blank), 16'd0);
    check("midrst_frame", 16'(o_frame), 16'd0);
    check("midrst_valid", 16'(o_valid), 16'd0);
    check("midrst_err", 16'(o_err), 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frames_ref = frames;
    hold_hex(2, 4'h3);
    hold_hex(3, 4'h4);
    repeat (4) @(negedge clk);
    check("midrst_no_partial_frame", 16'(frames), 16'(frames_ref));
    exp_q.push_back('{value: 16'h4365, dp: 4'h0, blank: 4'h0, err: 1'b0});
    hold_hex(0, 4'h5);
    hold_hex(1, 4'h6);
    drain("midrst_full_frame");

    hold(4'hF, 8'hFF, 10);
    check("total_frames", 16'(frames), 16'd7);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
